// File: rtl/div16_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock after the
// operands are accepted, with a direct path to completion on a zero divisor.
module div16_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_div;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic [WIDTH:0]        w_a_sh;
  logic signed [WIDTH:0] w_t;
  logic [WIDTH-1:0]      w_a_nxt;
  logic [WIDTH-1:0]      w_q_nxt;
  logic                  w_last;
  logic                  w_div_zero;

  // The partial remainder stays below the divisor, so it fits in WIDTH bits;
  // the extra bit only appears after the shift, inside the WIDTH+1 subtractor.
  assign w_a_sh     = {r_a, r_q[WIDTH-1]};
  assign w_t        = signed'(w_a_sh) - signed'({1'b0, r_div});
  assign w_a_nxt    = w_t[WIDTH] ? w_a_sh[WIDTH-1:0] : w_t[WIDTH-1:0];
  assign w_q_nxt    = {r_q[WIDTH-2:0], ~w_t[WIDTH]};
  assign w_last     = (r_count == CNT_W'(WIDTH - 1));
  assign w_div_zero = (divisor == '0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_div_zero ? S_DONE : S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_q         <= '0;
      r_div       <= '0;
      r_count     <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start && w_div_zero) begin
            r_quotient  <= '1;
            r_remainder <= dividend;
            r_dbz       <= 1'b1;
          end else if (start) begin
            r_div   <= divisor;
            r_q     <= dividend;
            r_a     <= '0;
            r_count <= '0;
          end
        end
        S_RUN: begin
          r_a     <= w_a_nxt;
          r_q     <= w_q_nxt;
          r_count <= r_count + CNT_W'(1);
          if (w_last) begin
            r_quotient  <= w_q_nxt;
            r_remainder <= w_a_nxt;
            r_dbz       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule
